// File: rtl/usb_rx_decoder_if.sv
// Result bundle from usb_rx_decoder to the payload buffer and protocol controller.
interface usb_rx_decoder_if;
   logic [2:0] RX_packet;
   logic       RX_data_ready;
   logic       RX_transfer_active;
   logic       RX_error;
   logic [7:0] RX_packet_data;
   logic       store_RX_packet_data;
   logic       flush;

   modport master (
      output RX_packet, RX_data_ready, RX_transfer_active, RX_error,
             RX_packet_data, store_RX_packet_data, flush
   );
   modport slave (
      input  RX_packet, RX_data_ready, RX_transfer_active, RX_error,
             RX_packet_data, store_RX_packet_data, flush
   );
endinterface

// File: rtl/usb_rx_decoder.sv
// Full-speed USB receive front end: line sync, bit recovery, NRZI decode, SYNC/PID/DATA/EOP framing.
// Optional bit unstuffing is enabled by defining USB_RX_BITSTUFF_EN.
module usb_rx_decoder #(
   parameter int BIT_PERIOD = 8,
   parameter int MAX_BYTES  = 64
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             dplus_in,
   input  logic             dminus_in,
   usb_rx_decoder_if.master rx
);
   localparam int TW = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 1;
   localparam int BW = $clog2(MAX_BYTES + 1);
   localparam logic [TW-1:0] T_LAST = TW'(BIT_PERIOD - 1);
   localparam logic [TW-1:0] T_SMP  = TW'(BIT_PERIOD / 2 - 1);
   localparam logic [BW-1:0] B_MAX  = BW'(MAX_BYTES);

   typedef enum logic [2:0] {S_IDLE, S_SYNC, S_PID, S_DATA, S_EOP, S_ERR} state_t;

   function automatic logic [2:0] pid_code(input logic [7:0] b);
      case (b)
         8'h2D:   return 3'd1;
         8'hA5:   return 3'd2;
         8'hE1:   return 3'd3;
         8'h33:   return 3'd4;
         8'hB4:   return 3'd5;
         default: return 3'd0;
      endcase
   endfunction

   // Synchronizers reset to J so releasing reset on an idle line is not a transition.
   logic dp_m, dp_s, dp_d, dm_m, dm_s, dm_d;
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         dp_m <= 1'b1; dp_s <= 1'b1; dp_d <= 1'b1;
         dm_m <= 1'b0; dm_s <= 1'b0; dm_d <= 1'b0;
      end else begin
         dp_m <= dplus_in;  dp_s <= dp_m; dp_d <= dp_s;
         dm_m <= dminus_in; dm_s <= dm_m; dm_d <= dm_s;
      end
   end

   logic          trans, smp;
   logic [TW-1:0] timer_q;
   assign trans = (dp_s != dp_d) || (dm_s != dm_d);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)                          timer_q <= '0;
      else if (trans || timer_q == T_LAST) timer_q <= '0;
      else                                 timer_q <= timer_q + TW'(1);
   end
   assign smp = (timer_q == T_SMP) && !trans;

   state_t        state_q, state_n;
   logic [2:0]    bit_cnt_q, bit_cnt_n;
   logic [7:0]    sr_q, sr_n;
   logic [BW-1:0] byte_cnt_q, byte_cnt_n;
   logic [1:0]    se0_cnt_q, se0_cnt_n;
   logic [2:0]    j_cnt_q, j_cnt_n;
   logic          prev_q, prev_n;
   logic [2:0]    pkt_q, pkt_n;
   logic          act_q, act_n, err_q, err_n;
   logic          ready_q, ready_n, store_q, store_n, flush_q, flush_n;
   logic [7:0]    pdata_q, pdata_n;

   logic       s_se0, s_j, s_bit, take, drop, stuff_bad, shift, last_bit;
   logic [7:0] byte_nxt;
   logic [2:0] code;

   assign s_se0    = !dp_s && !dm_s;
   assign s_j      = dp_s && !dm_s;
   assign s_bit    = (dp_s == prev_q);
   assign byte_nxt = {s_bit, sr_q[7:1]};
   assign take     = smp && !s_se0;
   assign code     = pid_code(byte_nxt);

`ifdef USB_RX_BITSTUFF_EN
   logic [2:0] ones_q, ones_n;
   assign drop      = take && (ones_q == 3'd6) && !s_bit;
   assign stuff_bad = take && (ones_q == 3'd6) && s_bit;

   always_comb begin
      ones_n = ones_q;
      if (drop)       ones_n = '0;
      else if (shift) ones_n = s_bit ? ones_q + 3'd1 : 3'd0;
      if (state_q == S_IDLE) ones_n = '0;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) ones_q <= '0;
      else        ones_q <= ones_n;
   end
`else
   assign drop      = 1'b0;
   assign stuff_bad = 1'b0;
`endif

   assign shift    = take && !drop && !stuff_bad;
   assign last_bit = shift && (bit_cnt_q == 3'd7);

   always_comb begin
      state_n    = state_q;
      bit_cnt_n  = bit_cnt_q;
      sr_n       = sr_q;
      byte_cnt_n = byte_cnt_q;
      se0_cnt_n  = se0_cnt_q;
      j_cnt_n    = j_cnt_q;
      prev_n     = prev_q;
      pkt_n      = pkt_q;
      act_n      = act_q;
      err_n      = err_q;
      pdata_n    = pdata_q;
      ready_n    = 1'b0;
      store_n    = 1'b0;
      flush_n    = 1'b0;

      if (take) prev_n = dp_s;
      if (shift) begin
         sr_n      = byte_nxt;
         bit_cnt_n = bit_cnt_q + 3'd1;
      end

      case (state_q)
         S_IDLE: begin
            prev_n    = 1'b1;
            bit_cnt_n = '0;
            sr_n      = '0;
            if (trans) begin
               state_n    = S_SYNC;
               byte_cnt_n = '0;
               se0_cnt_n  = '0;
               j_cnt_n    = '0;
               pkt_n      = '0;
               err_n      = 1'b0;
               act_n      = 1'b1;
            end
         end
         S_SYNC: begin
            if (smp && s_se0)   state_n = S_ERR;
            else if (stuff_bad) state_n = S_ERR;
            else if (last_bit)  state_n = (byte_nxt == 8'h80) ? S_PID : S_ERR;
         end
         S_PID: begin
            if (smp && s_se0)   state_n = S_ERR;
            else if (stuff_bad) state_n = S_ERR;
            else if (last_bit) begin
               pkt_n = code;
               if (code == 3'd4 || code == 3'd5) begin
                  flush_n    = 1'b1;
                  byte_cnt_n = '0;
                  state_n    = S_DATA;
               end else if (code != 3'd0) begin
                  se0_cnt_n = '0;
                  state_n   = S_EOP;
               end else begin
                  state_n = S_ERR;
               end
            end
         end
         S_DATA: begin
            if (smp && s_se0) begin
               if (bit_cnt_q == 3'd0) begin
                  se0_cnt_n = 2'd1;
                  state_n   = S_EOP;
               end else begin
                  state_n = S_ERR;
               end
            end else if (stuff_bad) begin
               state_n = S_ERR;
            end else if (last_bit) begin
               if (byte_cnt_q == B_MAX) begin
                  state_n = S_ERR;
               end else begin
                  pdata_n    = byte_nxt;
                  store_n    = 1'b1;
                  byte_cnt_n = byte_cnt_q + BW'(1);
               end
            end
         end
         S_EOP: begin
            if (smp) begin
               if (s_se0) begin
                  if (se0_cnt_q != 2'd2) se0_cnt_n = se0_cnt_q + 2'd1;
               end else if (s_j && se0_cnt_q == 2'd2) begin
                  ready_n = 1'b1;
                  act_n   = 1'b0;
                  state_n = S_IDLE;
               end else begin
                  state_n = S_ERR;
               end
            end
         end
         S_ERR: begin
            // Resynchronise on a complete EOP or on a long idle run, whichever comes first.
            if (smp) begin
               if (s_se0) begin
                  j_cnt_n = '0;
                  if (se0_cnt_q != 2'd2) se0_cnt_n = se0_cnt_q + 2'd1;
               end else if (s_j && (se0_cnt_q == 2'd2 || j_cnt_q == 3'd7)) begin
                  act_n   = 1'b0;
                  state_n = S_IDLE;
               end else if (s_j) begin
                  j_cnt_n   = j_cnt_q + 3'd1;
                  se0_cnt_n = '0;
               end else begin
                  j_cnt_n   = '0;
                  se0_cnt_n = '0;
               end
            end
         end
         default: state_n = S_IDLE;
      endcase

      if (state_n == S_ERR && state_q != S_ERR) begin
         err_n     = 1'b1;
         se0_cnt_n = {1'b0, smp && s_se0};
         j_cnt_n   = '0;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= S_IDLE;
         bit_cnt_q  <= '0;
         sr_q       <= '0;
         byte_cnt_q <= '0;
         se0_cnt_q  <= '0;
         j_cnt_q    <= '0;
         prev_q     <= 1'b1;
         pkt_q      <= '0;
         act_q      <= 1'b0;
         err_q      <= 1'b0;
         ready_q    <= 1'b0;
         store_q    <= 1'b0;
         flush_q    <= 1'b0;
         pdata_q    <= '0;
      end else begin
         state_q    <= state_n;
         bit_cnt_q  <= bit_cnt_n;
         sr_q       <= sr_n;
         byte_cnt_q <= byte_cnt_n;
         se0_cnt_q  <= se0_cnt_n;
         j_cnt_q    <= j_cnt_n;
         prev_q     <= prev_n;
         pkt_q      <= pkt_n;
         act_q      <= act_n;
         err_q      <= err_n;
         ready_q    <= ready_n;
         store_q    <= store_n;
         flush_q    <= flush_n;
         pdata_q    <= pdata_n;
      end
   end

   assign rx.RX_packet            = pkt_q;
   assign rx.RX_data_ready        = ready_q;
   assign rx.RX_transfer_active   = act_q;
   assign rx.RX_error             = err_q;
   assign rx.RX_packet_data       = pdata_q;
   assign rx.store_RX_packet_data = store_q;
   assign rx.flush                = flush_q;
endmodule

// File: tb/tb_usb_rx_decoder.sv
// Bench for usb_rx_decoder: encodes packets onto the D+/D- lines and checks against a packet-level model.
module tb_usb_rx_decoder;
   localparam int BP   = 8;
   localparam int MAXB = 64;
   localparam logic [1:0] SJ = 2'b10, SK = 2'b01, SZ = 2'b00;

   logic tb_clk = 1'b0;
   logic n_rst = 1'b0;
   logic dplus_in = 1'b1;
   logic dminus_in = 1'b0;

   usb_rx_decoder_if rx_if();

   usb_rx_decoder #(.BIT_PERIOD(BP), .MAX_BYTES(MAXB)) dut (
      .clk(tb_clk), .n_rst(n_rst), .dplus_in(dplus_in), .dminus_in(dminus_in), .rx(rx_if.master)
   );

   always #5 tb_clk = ~tb_clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Event monitor: counts pulses and logs every stored byte.
   int cyc = 0, ready_cnt = 0, flush_cnt = 0, st_n = 0, flush_cyc = 0, gap = 0;
   logic gap_armed = 1'b0;
   logic [7:0] st_mem [0:1023];
   always @(negedge tb_clk) begin
      cyc++;
      if (rx_if.RX_data_ready) ready_cnt++;
      if (rx_if.flush) begin
         flush_cnt++;
         flush_cyc = cyc;
         gap_armed = 1'b1;
      end
      if (rx_if.store_RX_packet_data) begin
         if (st_n < 1024) st_mem[st_n] = rx_if.RX_packet_data;
         st_n++;
         if (gap_armed) begin
            gap = cyc - flush_cyc;
            gap_armed = 1'b0;
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Line encoder: LSB first, NRZI (0 toggles), optional stuffing after six 1s.
   logic [1:0] sym_q[$];
   logic       lvl;
   int         ones;
   logic [7:0] pay [0:MAXB+3];

   task automatic push_bit(input logic b);
      if (!b) lvl = ~lvl;
      sym_q.push_back(lvl ? SJ : SK);
      ones = b ? ones + 1 : 0;
`ifdef USB_RX_BITSTUFF_EN
      if (ones == 6) begin
         lvl = ~lvl;
         sym_q.push_back(lvl ? SJ : SK);
         ones = 0;
      end
`endif
   endtask

   task automatic push_byte(input logic [7:0] b);
      for (int i = 0; i < 8; i++) push_bit(b[i]);
   endtask

   task automatic build(input logic [7:0] sync_b, input logic [7:0] pid_b, input int nb, input int partial);
      sym_q.delete();
      lvl  = 1'b1;
      ones = 0;
      push_byte(sync_b);
      push_byte(pid_b);
      for (int i = 0; i < nb; i++) push_byte(pay[i]);
      for (int i = 0; i < partial; i++) push_bit(1'($urandom_range(0, 1)));
      sym_q.push_back(SZ);
      sym_q.push_back(SZ);
      sym_q.push_back(SJ);
   endtask

   task automatic send(input int limit);
      for (int i = 0; i < limit && i < sym_q.size(); i++) begin
         {dplus_in, dminus_in} = sym_q[i];
         repeat (BP) @(negedge tb_clk);
      end
      {dplus_in, dminus_in} = SJ;
   endtask

   task automatic idle(input int nbits);
      {dplus_in, dminus_in} = SJ;
      repeat (nbits * BP) @(negedge tb_clk);
   endtask

   int d_ready, d_flush, d_st, st0;
   task automatic send_pkt(input logic [7:0] sync_b, input logic [7:0] pid_b, input int nb,
                           input int partial, input int idle_bits);
      int r0, f0;
      build(sync_b, pid_b, nb, partial);
      r0 = ready_cnt; f0 = flush_cnt; st0 = st_n;
      send(sym_q.size());
      idle(idle_bits);
      d_ready = ready_cnt - r0;
      d_flush = flush_cnt - f0;
      d_st    = st_n - st0;
   endtask

   // Packet-level reference: what the receiver must report for a given packet.
   typedef struct { logic [2:0] code; logic err; int ready; int nst; int nflush; } exp_t;
   function automatic exp_t model(input logic [7:0] sync_b, input logic [7:0] pid_b, input int nb, input int partial);
      exp_t e;
      e.code = 3'd0; e.err = 1'b0; e.ready = 0; e.nst = 0; e.nflush = 0;
      if (sync_b != 8'h80) begin e.err = 1'b1; return e; end
      case (pid_b)
         8'h2D: e.code = 3'd1;
         8'hA5: e.code = 3'd2;
         8'hE1: e.code = 3'd3;
         8'h33: e.code = 3'd4;
         8'hB4: e.code = 3'd5;
         default: e.code = 3'd0;
      endcase
      if (e.code == 3'd0) begin e.err = 1'b1; return e; end
      if (e.code >= 3'd4) begin
         e.nflush = 1;
         e.nst = (nb > MAXB) ? MAXB : nb;
         e.err = (nb > MAXB) || (partial != 0);
      end
      e.ready = e.err ? 0 : 1;
      return e;
   endfunction

   task automatic test_reset();
      n_rst = 1'b0;
      repeat (3) @(negedge tb_clk);
      n_cmp++;
      if ({rx_if.RX_packet, rx_if.RX_data_ready, rx_if.RX_transfer_active, rx_if.RX_error,
           rx_if.RX_packet_data, rx_if.store_RX_packet_data, rx_if.flush} !== 15'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got pkt=%0d act=%0b err=%0b data=%0h, want all 0",
                  rx_if.RX_packet, rx_if.RX_transfer_active, rx_if.RX_error, rx_if.RX_packet_data);
      end
      n_rst = 1'b1;
      idle(2);
   endtask

   task automatic test_ack();
      send_pkt(8'h80, 8'h2D, 0, 0, 3);
      n_cmp++; if (rx_if.RX_packet !== 3'd1) begin n_bad++; $display("FAIL ack_pkt: got %0d want 1", rx_if.RX_packet); end
      n_cmp++; if (d_ready != 1) begin n_bad++; $display("FAIL ack_ready: got %0d want 1", d_ready); end
      n_cmp++; if (d_st != 0) begin n_bad++; $display("FAIL ack_store: got %0d want 0", d_st); end
      n_cmp++; if (rx_if.RX_error !== 1'b0) begin n_bad++; $display("FAIL ack_err: got %0b want 0", rx_if.RX_error); end
      n_cmp++; if (rx_if.RX_transfer_active !== 1'b0) begin n_bad++; $display("FAIL ack_active: got %0b want 0", rx_if.RX_transfer_active); end
   endtask

   task automatic test_data0_fixed();
      for (int i = 0; i < 5; i++) pay[i] = 8'(i + 1);
      send_pkt(8'h80, 8'h33, 5, 0, 3);
      n_cmp++; if (d_flush != 1) begin n_bad++; $display("FAIL d0_flush: got %0d want 1", d_flush); end
      n_cmp++; if (d_st != 5) begin n_bad++; $display("FAIL d0_stores: got %0d want 5", d_st); end
      for (int i = 0; i < 5 && i < d_st; i++) begin
         n_cmp++;
         if (st_mem[st0 + i] !== 8'(i + 1)) begin
            n_bad++; $display("FAIL d0_byte[%0d]: got %0h want %0h", i, st_mem[st0 + i], i + 1);
         end
      end
      n_cmp++; if (rx_if.RX_packet !== 3'd4) begin n_bad++; $display("FAIL d0_pkt: got %0d want 4", rx_if.RX_packet); end
      n_cmp++; if (d_ready != 1) begin n_bad++; $display("FAIL d0_ready: got %0d want 1", d_ready); end
      n_cmp++; if (gap < 7) begin n_bad++; $display("FAIL d0_flush_gap: got %0d want >=7", gap); end
   endtask

   task automatic test_data_random();
      for (int k = 0; k < 6; k++) begin
         logic [7:0] pid;
         int nb;
         exp_t e;
         pid = ($urandom_range(0, 1) == 0) ? 8'h33 : 8'hB4;
         nb  = (k == 0) ? 0 : int'($urandom_range(1, 12));
         for (int i = 0; i < nb; i++) pay[i] = 8'($urandom);
         e = model(8'h80, pid, nb, 0);
         send_pkt(8'h80, pid, nb, 0, 2);
         n_cmp++; if (rx_if.RX_packet !== e.code) begin n_bad++; $display("FAIL rand[%0d]_pkt: got %0d want %0d", k, rx_if.RX_packet, e.code); end
         n_cmp++; if (rx_if.RX_error !== e.err) begin n_bad++; $display("FAIL rand[%0d]_err: got %0b want %0b", k, rx_if.RX_error, e.err); end
         n_cmp++; if (d_ready != e.ready) begin n_bad++; $display("FAIL rand[%0d]_ready: got %0d want %0d", k, d_ready, e.ready); end
         n_cmp++; if (d_flush != e.nflush) begin n_bad++; $display("FAIL rand[%0d]_flush: got %0d want %0d", k, d_flush, e.nflush); end
         n_cmp++; if (d_st != e.nst) begin n_bad++; $display("FAIL rand[%0d]_stores: got %0d want %0d", k, d_st, e.nst); end
         for (int i = 0; i < e.nst && i < d_st; i++) begin
            n_cmp++;
            if (st_mem[st0 + i] !== pay[i]) begin
               n_bad++; $display("FAIL rand[%0d]_byte[%0d]: got %0h want %0h", k, i, st_mem[st0 + i], pay[i]);
            end
         end
      end
   endtask

   task automatic test_bad_sync();
      send_pkt(8'h81, 8'h2D, 0, 0, 2);
      n_cmp++; if (rx_if.RX_error !== 1'b1) begin n_bad++; $display("FAIL badsync_err: got %0b want 1", rx_if.RX_error); end
      n_cmp++; if (d_ready != 0) begin n_bad++; $display("FAIL badsync_ready: got %0d want 0", d_ready); end
      idle(8);
      send_pkt(8'h80, 8'h2D, 0, 0, 3);
      n_cmp++; if (rx_if.RX_error !== 1'b0) begin n_bad++; $display("FAIL badsync_recover_err: got %0b want 0", rx_if.RX_error); end
      n_cmp++; if (rx_if.RX_packet !== 3'd1) begin n_bad++; $display("FAIL badsync_recover_pkt: got %0d want 1", rx_if.RX_packet); end
      n_cmp++; if (d_ready != 1) begin n_bad++; $display("FAIL badsync_recover_ready: got %0d want 1", d_ready); end
   endtask

   task automatic test_max_len();
      for (int i = 0; i < MAXB + 1; i++) pay[i] = 8'($urandom);
      send_pkt(8'h80, 8'hB4, MAXB, 0, 3);
      n_cmp++; if (d_st != MAXB) begin n_bad++; $display("FAIL max64_stores: got %0d want %0d", d_st, MAXB); end
      n_cmp++; if (d_ready != 1) begin n_bad++; $display("FAIL max64_ready: got %0d want 1", d_ready); end
      n_cmp++; if (rx_if.RX_packet !== 3'd5) begin n_bad++; $display("FAIL max64_pkt: got %0d want 5", rx_if.RX_packet); end
      for (int i = 0; i < MAXB && i < d_st; i++) begin
         n_cmp++;
         if (st_mem[st0 + i] !== pay[i]) begin
            n_bad++; $display("FAIL max64_byte[%0d]: got %0h want %0h", i, st_mem[st0 + i], pay[i]);
         end
      end
      send_pkt(8'h80, 8'hB4, MAXB + 1, 0, 3);
      n_cmp++; if (d_st != MAXB) begin n_bad++; $display("FAIL max65_stores: got %0d want %0d", d_st, MAXB); end
      n_cmp++; if (d_ready != 0) begin n_bad++; $display("FAIL max65_ready: got %0d want 0", d_ready); end
      n_cmp++; if (rx_if.RX_error !== 1'b1) begin n_bad++; $display("FAIL max65_err: got %0b want 1", rx_if.RX_error); end
   endtask

   task automatic test_se0_midbyte();
      pay[0] = 8'hA7; pay[1] = 8'h3C;
      send_pkt(8'h80, 8'h33, 2, 4, 3);
      n_cmp++; if (rx_if.RX_error !== 1'b1) begin n_bad++; $display("FAIL midse0_err: got %0b want 1", rx_if.RX_error); end
      n_cmp++; if (d_st != 2) begin n_bad++; $display("FAIL midse0_stores: got %0d want 2", d_st); end
      n_cmp++; if (d_ready != 0) begin n_bad++; $display("FAIL midse0_ready: got %0d want 0", d_ready); end
      n_cmp++; if (d_st >= 2 && st_mem[st0 + 1] !== 8'h3C) begin n_bad++; $display("FAIL midse0_byte1: got %0h want 3c", st_mem[st0 + 1]); end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 6; k++) begin
         logic [7:0] pid;
         exp_t e;
         case ($urandom_range(0, 3))
            0: pid = 8'h2D;
            1: pid = 8'hA5;
            2: pid = 8'hE1;
            default: pid = 8'($urandom);
         endcase
         e = model(8'h80, pid, 0, 0);
         if (e.code >= 3'd4) pid = 8'h2D;
         e = model(8'h80, pid, 0, 0);
         send_pkt(8'h80, pid, 0, 0, 2);
         n_cmp++; if (rx_if.RX_packet !== e.code) begin n_bad++; $display("FAIL b2b[%0d]_pkt: got %0d want %0d pid=%0h", k, rx_if.RX_packet, e.code, pid); end
         n_cmp++; if (rx_if.RX_error !== e.err) begin n_bad++; $display("FAIL b2b[%0d]_err: got %0b want %0b", k, rx_if.RX_error, e.err); end
         n_cmp++; if (d_ready != e.ready) begin n_bad++; $display("FAIL b2b[%0d]_ready: got %0d want %0d", k, d_ready, e.ready); end
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) pay[i] = 8'(i + 1);
      build(8'h80, 8'h33, 5, 0);
      send(28);
      n_cmp++; if (rx_if.RX_transfer_active !== 1'b1) begin n_bad++; $display("FAIL rstmid_active_before: got %0b want 1", rx_if.RX_transfer_active); end
      n_rst = 1'b0;
      #1;
      n_cmp++;
      if ({rx_if.RX_packet, rx_if.RX_data_ready, rx_if.RX_transfer_active, rx_if.RX_error,
           rx_if.RX_packet_data, rx_if.store_RX_packet_data, rx_if.flush} !== 15'd0) begin
         n_bad++;
         $display("FAIL rstmid_outputs: got pkt=%0d act=%0b data=%0h, want all 0",
                  rx_if.RX_packet, rx_if.RX_transfer_active, rx_if.RX_packet_data);
      end
      repeat (3) @(negedge tb_clk);
      n_rst = 1'b1;
      idle(2);
      send_pkt(8'h80, 8'h2D, 0, 0, 3);
      n_cmp++; if (rx_if.RX_packet !== 3'd1) begin n_bad++; $display("FAIL rstmid_ack_pkt: got %0d want 1", rx_if.RX_packet); end
      n_cmp++; if (d_ready != 1) begin n_bad++; $display("FAIL rstmid_ack_ready: got %0d want 1", d_ready); end
   endtask

   task automatic test_all_ones();
      pay[0] = 8'hFF;
      send_pkt(8'h80, 8'h33, 1, 0, 3);
      n_cmp++; if (d_st != 1) begin n_bad++; $display("FAIL ff_stores: got %0d want 1", d_st); end
      n_cmp++; if (d_st >= 1 && st_mem[st0] !== 8'hFF) begin n_bad++; $display("FAIL ff_byte: got %0h want ff", st_mem[st0]); end
      n_cmp++; if (rx_if.RX_error !== 1'b0) begin n_bad++; $display("FAIL ff_err: got %0b want 0", rx_if.RX_error); end
      n_cmp++; if (d_ready != 1) begin n_bad++; $display("FAIL ff_ready: got %0d want 1", d_ready); end
   endtask

   initial begin
      test_reset();
      test_ack();
      test_data0_fixed();
      test_data_random();
      test_bad_sync();
      test_max_len();
      test_se0_midbyte();
      test_back_to_back();
      test_reset_mid();
      test_all_ones();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/usb_rx_decoder.md
# usb_rx_decoder

Full-speed USB receive front end: recovers bits from the differential line, NRZI-decodes them and frames SYNC/PID/data/EOP. It sits at the pin side, symmetric to the transmitter that drives `dplus_out`/`dminus_out`. Payload bytes are pushed into `data_buffer64` through its `RX_packet_data`/`store_RX_packet_data` inputs, and a packet code is reported to the protocol controller. The line format is the transmitter's format: 8 clk per bit, idle J (dplus=1, dminus=0), LSB first, EOP = 2 bit times SE0 then J.

## Interface
- `BIT_PERIOD`, 8, clocks per bit; must be ≥4
- `MAX_BYTES`, 64, maximum payload bytes per packet
- `clk` in 1: system clock; all logic posedge
- `n_rst` in 1: asynchronous active-low reset
- `dplus_in` in 1: raw D+ line, asynchronous to `clk`
- `dminus_in` in 1: raw D− line, asynchronous to `clk`
- `RX_packet` out 3: last PID code; 0 none, 1 ACK, 2 NAK, 3 STALL, 4 DATA0, 5 DATA1
- `RX_data_ready` out 1: 1-cycle pulse, packet complete without error
- `RX_transfer_active` out 1: high while a packet is being received
- `RX_error` out 1: packet error flag
- `RX_packet_data` out 8: decoded payload byte
- `store_RX_packet_data` out 1: 1-cycle write strobe to the buffer
- `flush` out 1: 1-cycle pulse that clears the buffer before payload arrives

## Operation
- Input conditioning:
  - Each line passes through a 2-flop synchronizer.
  - A transition is any change of the synced (dplus, dminus) pair.
- Bit timer:
  - Counts 0..BIT_PERIOD−1 and wraps.
  - Resets to 0 on every transition.
  - The bit is sampled when timer == BIT_PERIOD/2 − 1.
- NRZI decode:
  - Same dplus level as previous sample → 1. Change → 0.
  - The previous level is initialised to J (1) in IDLE.
  - An SE0 sample is flagged separately and is not decoded.
- State machine:
  - IDLE: first transition → SYNC. Bit counter and shift register are cleared; RX_packet ← 0, RX_error ← 0, RX_transfer_active ← 1.
  - SYNC: shifts 8 bits. Decoded byte 8'h80 → PID. Any other byte, or an SE0 sample → ERR.
  - PID: shifts 8 bits. Byte 8'h2D→1, 8'hA5→2, 8'hE1→3, 8'h33→4, 8'hB4→5; RX_packet is loaded the cycle after the 8th sample. Codes 4/5 pulse `flush` and go to DATA. Codes 1–3 go to EOP. Any other byte → ERR.
  - DATA: each completed byte drives RX_packet_data and pulses store. SE0 on a byte boundary → EOP. SE0 mid-byte, or byte number MAX_BYTES+1 → ERR. Zero-length data is legal.
  - EOP: requires 2 consecutive SE0 samples followed by a J sample, then → IDLE with an RX_data_ready pulse and RX_transfer_active ← 0. A K sample, a missing SE0, or a data bit after a handshake PID → ERR.
  - ERR: RX_error ← 1, held until the next IDLE→SYNC. Leaves for IDLE after a full SE0+J EOP, or after 8 consecutive J samples. RX_transfer_active ← 0 on leaving ERR.
- Reset: async, mid-packet allowed. All outputs ← 0, state ← IDLE, previous level ← J. The partial packet is discarded.

## Timing
- Line edge → synced edge: 2 cycles.
- Bit sample: BIT_PERIOD/2−1 cycles after the synced edge (3 at default).
- `store_RX_packet_data` and `RX_packet_data` are asserted together, the cycle after the 8th bit sample of a byte; RX_packet_data stays valid until the next store.
- `flush` fires the cycle after the last PID bit sample, at least 7 cycles before the first store.
- `RX_data_ready` fires the cycle after the J sample that ends EOP; RX_packet is already valid and stays held until the next sync.
- Outputs are registered with no combinational path from the lines.

## Configuration
- `USB_RX_BITSTUFF_EN` defined: after six consecutive decoded 1s, the next bit must be 0 and is discarded (not shifted, not counted). If that bit is a 1 → ERR. The ones-counter resets on every 0 and on SYNC entry.
- `USB_RX_BITSTUFF_EN` undefined: no unstuffing, every bit is shifted. This matches the current transmitter, which does not stuff.

## Test plan
- Reset mid-DATA: `n_rst`=0 at byte 2 of a DATA0 packet → all outputs 0 within 1 cycle. A following clean ACK decodes with RX_packet=1.
- ACK packet: bits SYNC 8'h80, PID 8'h2D, EOP driven at 8 clk/bit → RX_packet=1, RX_data_ready pulse, no store, RX_error=0.
- DATA0 with bytes 1,2,3,4,5 → one flush pulse, then five stores carrying 1..5 in order, RX_packet=4, RX_data_ready once.
- Bad SYNC 8'h81 → RX_error=1, no RX_data_ready. After 8 idle bits, an ACK decodes with RX_error cleared.
- DATA1 with 64 bytes → 64 stores and ready. DATA1 with 65 bytes → 64 stores, then RX_error=1.
- SE0 after 4 bits of a data byte → RX_error=1, no store for the partial byte. With `USB_RX_BITSTUFF_EN`: byte 8'hFF sent stuffed → stored as 8'hFF.
